// File: rtl/best_stream.sv
// ---------------------------------------------------------------------------
// best_stream
//   Streaming argmax over one GA generation. Fitness values arrive LANES per
//   beat (lane k of beat b is individual b*LANES+k) over POP/LANES beats. The
//   block reports the index and value of the fittest individual; ties resolve
//   to the lowest index (signed compare, replace only on strictly greater).
//
// Ports
//   clk           rising-edge clock
//   reset         synchronous active-high reset
//   start         begin (or restart) a generation scan
//   in_valid      fitness_in carries a beat
//   in_ready      beat accepted on an edge with in_valid & in_ready
//   fitness_in    LANES packed signed values, lane k = [k*FIT_W +: FIT_W]
//   busy          scan in progress
//   done          one-cycle pulse, index/best_fitness valid
//   index         index of best individual, held until the next result
//   best_fitness  fitness of that individual
//   elite_fitness best fitness across generations   (BEST_STREAM_ELITE_EN)
//   elite_update  pulses with done when elite moved  (BEST_STREAM_ELITE_EN)
//
// Optional feature: define BEST_STREAM_ELITE_EN to add the elite tracker.
// ---------------------------------------------------------------------------
module best_stream #(
    parameter int FIT_W = 27,
    parameter int POP   = 16,
    parameter int LANES = 2,
    parameter int IDX_W = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [LANES*FIT_W-1:0]   fitness_in,
    output logic                     busy,
    output logic                     done,
    output logic [IDX_W-1:0]         index,
    output logic signed [FIT_W-1:0]  best_fitness
`ifdef BEST_STREAM_ELITE_EN
    ,
    output logic signed [FIT_W-1:0]  elite_fitness,
    output logic                     elite_update
`endif
);

    localparam int BEATS = POP / LANES;
    localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SCAN   = 2'd1,
        ST_REPORT = 2'd2
    } state_t;

    state_t                   state_q;
    logic [CNT_W-1:0]         cnt_q;
    logic signed [FIT_W-1:0]  run_fit_q;
    logic [IDX_W-1:0]         run_idx_q;
    logic signed [FIT_W-1:0]  best_q;
    logic [IDX_W-1:0]         index_q;
    logic                     done_q;
    logic                     busy_q;
    logic                     in_ready_q;

    // Unpack the lanes of the current beat.
    logic signed [FIT_W-1:0]  lane_fit [LANES];

    for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
        assign lane_fit[gi] = fitness_in[gi*FIT_W +: FIT_W];
    end

    // Beat-local winner: lanes resolved lowest-first, strict greater.
    logic [IDX_W-1:0]         beat_base;
    logic signed [FIT_W-1:0]  beat_fit;
    logic [IDX_W-1:0]         beat_idx;

    assign beat_base = IDX_W'(cnt_q) * IDX_W'(LANES);

    always_comb begin
        beat_fit = lane_fit[0];
        beat_idx = beat_base;
        for (int k = 1; k < LANES; k++) begin
            if (lane_fit[k] > beat_fit) begin
                beat_fit = lane_fit[k];
                beat_idx = beat_base + IDX_W'(k);
            end
        end
    end

    // Running max after merging this beat. Beat 0 loads unconditionally so an
    // all-minimum population still resolves to individual 0.
    logic signed [FIT_W-1:0]  run_fit_d;
    logic [IDX_W-1:0]         run_idx_d;

    always_comb begin
        run_fit_d = run_fit_q;
        run_idx_d = run_idx_q;
        if ((cnt_q == '0) || (beat_fit > run_fit_q)) begin
            run_fit_d = beat_fit;
            run_idx_d = beat_idx;
        end
    end

    // A start seen during SCAN aborts the scan, so it blocks acceptance.
    logic accept;
    logic last_accept;

    assign accept      = (state_q == ST_SCAN) && !start && in_valid;
    assign last_accept = accept && (cnt_q == CNT_W'(BEATS - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            run_fit_q  <= '0;
            run_idx_q  <= '0;
            best_q     <= '0;
            index_q    <= '0;
            done_q     <= 1'b0;
            busy_q     <= 1'b0;
            in_ready_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        state_q    <= ST_SCAN;
                        cnt_q      <= '0;
                        run_fit_q  <= '0;
                        run_idx_q  <= '0;
                        busy_q     <= 1'b1;
                        in_ready_q <= 1'b1;
                    end
                end
                ST_SCAN: begin
                    if (start) begin
                        cnt_q     <= '0;
                        run_fit_q <= '0;
                        run_idx_q <= '0;
                    end else if (in_valid) begin
                        run_fit_q <= run_fit_d;
                        run_idx_q <= run_idx_d;
                        if (last_accept) begin
                            state_q    <= ST_REPORT;
                            cnt_q      <= '0;
                            busy_q     <= 1'b0;
                            in_ready_q <= 1'b0;
                            done_q     <= 1'b1;
                            index_q    <= run_idx_d;
                            best_q     <= run_fit_d;
                        end else begin
                            cnt_q <= cnt_q + CNT_W'(1);
                        end
                    end
                end
                ST_REPORT: begin
                    if (start) begin
                        state_q    <= ST_SCAN;
                        cnt_q      <= '0;
                        run_fit_q  <= '0;
                        run_idx_q  <= '0;
                        busy_q     <= 1'b1;
                        in_ready_q <= 1'b1;
                    end else begin
                        state_q <= ST_IDLE;
                    end
                end
                default: begin
                    state_q    <= ST_IDLE;
                    busy_q     <= 1'b0;
                    in_ready_q <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready     = in_ready_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign index        = index_q;
    assign best_fitness = best_q;

`ifdef BEST_STREAM_ELITE_EN
    // Elite survives start; only reset clears it.
    logic signed [FIT_W-1:0]  elite_fit_q;
    logic                     elite_update_q;
    logic                     elite_valid_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            elite_fit_q    <= '0;
            elite_update_q <= 1'b0;
            elite_valid_q  <= 1'b0;
        end else begin
            elite_update_q <= 1'b0;
            if (last_accept && (!elite_valid_q || (run_fit_d > elite_fit_q))) begin
                elite_fit_q    <= run_fit_d;
                elite_update_q <= 1'b1;
                elite_valid_q  <= 1'b1;
            end
        end
    end

    assign elite_fitness = elite_fit_q;
    assign elite_update  = elite_update_q;
`endif

endmodule

// File: tb/tb_best_stream.sv
// ---------------------------------------------------------------------------
// tb_best_stream
//   Directed bench for best_stream with POP=16, LANES=2, FIT_W=27, IDX_W=8.
//   Inputs are driven and outputs sampled 1 time unit after each rising edge.
// ---------------------------------------------------------------------------
module tb_best_stream;

    localparam int FIT_W = 27;
    localparam int POP   = 16;
    localparam int LANES = 2;
    localparam int IDX_W = 8;

    logic                     clk = 1'b0;
    logic                     reset;
    logic                     start;
    logic                     in_valid;
    logic                     in_ready;
    logic [LANES*FIT_W-1:0]   fitness_in;
    logic                     busy;
    logic                     done;
    logic [IDX_W-1:0]         index;
    logic signed [FIT_W-1:0]  best_fitness;
`ifdef BEST_STREAM_ELITE_EN
    logic signed [FIT_W-1:0]  elite_fitness;
    logic                     elite_update;
`endif

    int checks = 0;
    int errors = 0;

    logic signed [FIT_W-1:0]  pop [POP];

    best_stream #(
        .FIT_W (FIT_W),
        .POP   (POP),
        .LANES (LANES),
        .IDX_W (IDX_W)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .fitness_in   (fitness_in),
        .busy         (busy),
        .done         (done),
        .index        (index),
        .best_fitness (best_fitness)
`ifdef BEST_STREAM_ELITE_EN
        ,
        .elite_fitness(elite_fitness),
        .elite_update (elite_update)
`endif
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic fill_pop(input logic signed [FIT_W-1:0] v);
        for (int i = 0; i < POP; i++) pop[i] = v;
    endtask

    // Start a scan and stream pop[] until done is seen (bounded). Optionally
    // holds in_valid low for stall_len cycles once stall_at beats are in.
    // cyc counts edges after the start edge up to the one that raised done.
    task automatic do_scan(input int stall_at, input int stall_len, output int cyc);
        int b;
        int stalled;
        logic acc;
        start = 1'b1;
        in_valid = 1'b0;
        tick();
        start = 1'b0;
        cyc = 0;
        b = 0;
        stalled = 0;
        while (done !== 1'b1 && cyc < 40) begin
            if (b == stall_at && stalled < stall_len) begin
                in_valid = 1'b0;
                stalled++;
            end else if (b < POP / LANES) begin
                in_valid = 1'b1;
                fitness_in = {pop[2*b+1], pop[2*b]};
            end else begin
                in_valid = 1'b0;
            end
            acc = in_valid & in_ready;
            tick();
            cyc++;
            if (acc) b++;
        end
        in_valid = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        start = 1'b0;
        in_valid = 1'b0;
        fitness_in = '0;
        tick();
        tick();
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready: got %b want 0", in_ready); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", done); end
        checks++; if (index !== 8'd0) begin errors++; $display("FAIL reset_index: got %0d want 0", index); end
        checks++; if (best_fitness !== 27'sd0) begin errors++; $display("FAIL reset_best: got %0d want 0", best_fitness); end
        reset = 1'b0;
        tick();
        $display("test_reset: in_ready=%b busy=%b done=%b index=%0d best=%0d", in_ready, busy, done, index, best_fitness);
    endtask

    task automatic test_single_max();
        int cyc;
        fill_pop('0);
        pop[5] = 27'sh3FF_FFFF;
        do_scan(-1, 0, cyc);
        checks++; if (cyc !== 8) begin errors++; $display("FAIL single_latency: got %0d cycles want 8", cyc); end
        checks++; if (index !== 8'd5) begin errors++; $display("FAIL single_index: got %0d want 5", index); end
        checks++; if (best_fitness !== 27'sh3FF_FFFF) begin errors++; $display("FAIL single_best: got %h want 3ffffff", best_fitness); end
        checks++; if (busy !== 1'b0 || in_ready !== 1'b0) begin errors++; $display("FAIL single_report_flags: busy=%b in_ready=%b want 0 0", busy, in_ready); end
        tick();
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL single_done_width: got %b want 0", done); end
        checks++; if (index !== 8'd5) begin errors++; $display("FAIL single_hold: got %0d want 5", index); end
        $display("test_single_max: cycles=%0d index=%0d best=%h", cyc, index, best_fitness);
    endtask

    task automatic test_ties();
        int cyc;
        fill_pop(-27'sd67108864);
        do_scan(-1, 0, cyc);
        checks++; if (index !== 8'd0) begin errors++; $display("FAIL tie_allmin_index: got %0d want 0", index); end
        checks++; if (best_fitness !== -27'sd67108864) begin errors++; $display("FAIL tie_allmin_best: got %0d want -67108864", best_fitness); end
        $display("test_ties allmin: index=%0d best=%0d", index, best_fitness);
        tick();

        fill_pop(27'sd1);
        pop[3] = 27'sd100;
        pop[9] = 27'sd100;
        do_scan(-1, 0, cyc);
        checks++; if (index !== 8'd3) begin errors++; $display("FAIL tie_beats_index: got %0d want 3", index); end
        checks++; if (best_fitness !== 27'sd100) begin errors++; $display("FAIL tie_beats_best: got %0d want 100", best_fitness); end
        $display("test_ties beats: index=%0d best=%0d", index, best_fitness);
        tick();

        fill_pop(-27'sd9);
        pop[10] = -27'sd5;
        pop[11] = -27'sd5;
        do_scan(-1, 0, cyc);
        checks++; if (index !== 8'd10) begin errors++; $display("FAIL tie_lanes_index: got %0d want 10", index); end
        $display("test_ties lanes: index=%0d best=%0d", index, best_fitness);
        tick();

        fill_pop(27'sd3);
        pop[15] = 27'sd4;
        do_scan(-1, 0, cyc);
        checks++; if (index !== 8'd15) begin errors++; $display("FAIL last_index: got %0d want 15", index); end
        $display("test_ties last: index=%0d best=%0d", index, best_fitness);
        tick();
    endtask

    task automatic test_stall();
        int cyc;
        fill_pop('0);
        pop[5] = 27'sh3FF_FFFF;
        do_scan(3, 3, cyc);
        checks++; if (cyc !== 11) begin errors++; $display("FAIL stall_latency: got %0d cycles want 11", cyc); end
        checks++; if (index !== 8'd5) begin errors++; $display("FAIL stall_index: got %0d want 5", index); end
        $display("test_stall: cycles=%0d index=%0d", cyc, index);
        tick();
    endtask

    task automatic test_restart();
        int ndone;
        int cyc;
        ndone = 0;
        fill_pop('0);
        pop[1] = 27'sd1000;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int b = 0; b < 5; b++) begin
            in_valid = 1'b1;
            fitness_in = {pop[2*b+1], pop[2*b]};
            tick();
            if (done === 1'b1) ndone++;
        end
        in_valid = 1'b0;
        fill_pop('0);
        pop[12] = 27'sd7;
        start = 1'b1;
        tick();
        start = 1'b0;
        if (done === 1'b1) ndone++;
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL restart_busy: got %b want 1", busy); end
        cyc = 0;
        for (int b = 0; b < 8; b++) begin
            in_valid = 1'b1;
            fitness_in = {pop[2*b+1], pop[2*b]};
            tick();
            if (done === 1'b1) ndone++;
        end
        in_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (done === 1'b1) ndone++;
        end
        checks++; if (ndone !== 1) begin errors++; $display("FAIL restart_done_count: got %0d want 1", ndone); end
        checks++; if (index !== 8'd12) begin errors++; $display("FAIL restart_index: got %0d want 12", index); end
        checks++; if (best_fitness !== 27'sd7) begin errors++; $display("FAIL restart_best: got %0d want 7", best_fitness); end
        $display("test_restart: dones=%0d index=%0d best=%0d", ndone, index, best_fitness);
    endtask

    task automatic test_reset_mid_scan();
        int ndone;
        int cyc;
        ndone = 0;
        fill_pop('0);
        pop[9] = 27'sd55;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int b = 0; b < 7; b++) begin
            in_valid = 1'b1;
            fitness_in = {pop[2*b+1], pop[2*b]};
            tick();
            if (done === 1'b1) ndone++;
        end
        in_valid = 1'b0;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midreset_busy: got %b want 0", busy); end
        checks++; if (index !== 8'd0 || best_fitness !== 27'sd0) begin errors++; $display("FAIL midreset_result: index=%0d best=%0d want 0 0", index, best_fitness); end
        for (int i = 0; i < 4; i++) begin
            tick();
            if (done === 1'b1) ndone++;
        end
        checks++; if (ndone !== 0) begin errors++; $display("FAIL midreset_done: got %0d pulses want 0", ndone); end
        fill_pop('0);
        pop[5] = 27'sh3FF_FFFF;
        do_scan(-1, 0, cyc);
        checks++; if (cyc !== 8 || index !== 8'd5) begin errors++; $display("FAIL midreset_rescan: cycles=%0d index=%0d want 8 5", cyc, index); end
        $display("test_reset_mid_scan: dones=%0d rescan index=%0d", ndone, index);
        tick();
    endtask

    // Second scan starts while the first is in REPORT.
    task automatic test_back_to_back();
        int cyc;
        fill_pop(27'sd2);
        pop[0] = 27'sd9;
        do_scan(-1, 0, cyc);
        checks++; if (index !== 8'd0) begin errors++; $display("FAIL b2b_first_index: got %0d want 0", index); end
        fill_pop(-27'sd3);
        pop[14] = 27'sd0;
        do_scan(-1, 0, cyc);
        checks++; if (cyc !== 8) begin errors++; $display("FAIL b2b_latency: got %0d want 8", cyc); end
        checks++; if (index !== 8'd14) begin errors++; $display("FAIL b2b_index: got %0d want 14", index); end
        $display("test_back_to_back: cycles=%0d index=%0d", cyc, index);
        tick();
    endtask

    task automatic test_random();
        int cyc;
        int exp_idx;
        logic signed [FIT_W-1:0] exp_fit;
        for (int r = 0; r < 12; r++) begin
            for (int i = 0; i < POP; i++) begin
                if (r < 2) pop[i] = FIT_W'($urandom);
                else pop[i] = FIT_W'($urandom_range(0, 7)) - 27'sd4;
            end
            exp_fit = pop[0];
            exp_idx = 0;
            for (int i = 1; i < POP; i++) begin
                if (pop[i] > exp_fit) begin
                    exp_fit = pop[i];
                    exp_idx = i;
                end
            end
            do_scan(-1, 0, cyc);
            checks++;
            if (index !== 8'(exp_idx) || best_fitness !== exp_fit) begin
                errors++;
                $display("FAIL random_%0d: index=%0d best=%0d want %0d %0d", r, index, best_fitness, exp_idx, exp_fit);
            end
            $display("test_random %0d: index=%0d best=%0d", r, index, best_fitness);
            tick();
        end
    endtask

`ifdef BEST_STREAM_ELITE_EN
    task automatic test_elite();
        int cyc;
        logic signed [FIT_W-1:0] gmax [3];
        logic exp_upd [3];
        logic signed [FIT_W-1:0] exp_el [3];
        gmax[0] = 27'sd50; gmax[1] = 27'sd20; gmax[2] = 27'sd70;
        exp_upd[0] = 1'b1; exp_upd[1] = 1'b0; exp_upd[2] = 1'b1;
        exp_el[0] = 27'sd50; exp_el[1] = 27'sd50; exp_el[2] = 27'sd70;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checks++; if (elite_fitness !== 27'sd0 || elite_update !== 1'b0) begin errors++; $display("FAIL elite_reset: fit=%0d upd=%b want 0 0", elite_fitness, elite_update); end
        for (int g = 0; g < 3; g++) begin
            fill_pop(-27'sd1);
            pop[g + 4] = gmax[g];
            do_scan(-1, 0, cyc);
            checks++;
            if (elite_update !== exp_upd[g] || elite_fitness !== exp_el[g]) begin
                errors++;
                $display("FAIL elite_gen%0d: upd=%b fit=%0d want %b %0d", g + 1, elite_update, elite_fitness, exp_upd[g], exp_el[g]);
            end
            $display("test_elite gen%0d: upd=%b elite=%0d", g + 1, elite_update, elite_fitness);
            tick();
            checks++; if (elite_update !== 1'b0) begin errors++; $display("FAIL elite_pulse_gen%0d: got %b want 0", g + 1, elite_update); end
        end
    endtask
`endif

    initial begin
        test_reset();
        test_single_max();
        test_ties();
        test_stall();
        test_restart();
        test_reset_mid_scan();
        test_back_to_back();
        test_random();
`ifdef BEST_STREAM_ELITE_EN
        test_elite();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
